uart_tx_framer: RTL and testbench

//  Serial transmitter: accepts a parallel word via valid/ready and emits one async frame on serial_out.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/flex_pts_sr.sv | 39 +++
 rtl/uart_tx_framer.sv | 124 ++++++++++++
 tb/tb_uart_tx_framer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame states, width constants and parity.
package uart_pkg;

    localparam int unsigned DataBitsMax = 9;
    // Wide enough to count data bits and stop bits.
    localparam int unsigned CntW        = $clog2(DataBitsMax);

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StStart  = 3'd1;
    localparam state_t StData   = 3'd2;
    localparam state_t StParity = 3'd3;
    localparam state_t StStop   = 3'd4;

    function automatic logic parity_bit(input logic [DataBitsMax-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; resets to all ones so an idle line reads high.
module flex_pts_sr #(
    parameter int unsigned NUM_BITS  = 4,
    parameter int unsigned SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable_i,
    input  logic                load_enable_i,
    input  logic [NUM_BITS-1:0] parallel_in_i,
    output logic                serial_out_o
);

    logic [NUM_BITS-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_enable_i) begin
            sr_d = parallel_in_i;
        end else if (shift_enable_i) begin
            if (SHIFT_MSB != 0) begin
                sr_d = {sr_q[NUM_BITS-2:0], 1'b1};
            end else begin
                sr_d = {1'b1, sr_q[NUM_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign serial_out_o = (SHIFT_MSB != 0) ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/uart_tx_framer.sv
// Async serial transmitter: start bit, LSB-first data, optional parity, stop bit(s).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 serial_out_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]   DataLast  = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0]   StopLast  = CntW'(STOP_BITS - 1);

    state_t              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                parity_q, parity_d;
    logic                handshake, bit_done, sr_out;

    assign handshake = tx_valid_i && (state_q == StIdle);
    assign bit_done  = (state_q != StIdle) && (timer_q == TimerLast);

    flex_pts_sr #(
        .NUM_BITS  (DATA_BITS),
        .SHIFT_MSB (0)
    ) u_shifter (
        .clk            (clk),
        .n_rst          (n_rst),
        .shift_enable_i (bit_done && (state_q == StData)),
        .load_enable_i  (handshake),
        .parallel_in_i  (tx_data_i),
        .serial_out_o   (sr_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        timer_d  = (state_q == StIdle || bit_done) ? '0 : timer_q + 1'b1;
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d  = StStart;
                    parity_d = parity_bit(DataBitsMax'(tx_data_i), PARITY_ODD != 0);
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (cnt_q == StopLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
        end
    end

    // Line level is selected purely from registered state, so it cannot glitch mid-bit.
    always_comb begin
        serial_out_o = 1'b1;
        case (state_q)
            StStart:  serial_out_o = 1'b0;
            StData:   serial_out_o = sr_out;
            StParity: serial_out_o = parity_q;
            default:  serial_out_o = 1'b1;
        endcase
    end

    assign tx_ready_o = (state_q == StIdle);
    assign tx_busy_o  = (state_q != StIdle);
    assign tx_done_o  = (state_q == StStop) && bit_done && (cnt_q == StopLast);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four parameterisations sharing clock, reset and data bus.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic [3:0] v, ser, rdy, busy, done;
    int         errors = 0;
    int         checks = 0;
    logic [15:0] f;

    always #5 clk = ~clk;

    // 0: plain 8N1, 1: even parity, 2: odd parity, 3: two stop bits at 2 clocks/bit
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(1)) dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data_i(tx_data), .tx_valid_i(v[0]), .tx_ready_o(rdy[0]),
        .serial_out_o(ser[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0),
                     .STOP_BITS(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data_i(tx_data), .tx_valid_i(v[1]), .tx_ready_o(rdy[1]),
        .serial_out_o(ser[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1),
                     .STOP_BITS(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .tx_data_i(tx_data), .tx_valid_i(v[2]), .tx_ready_o(rdy[2]),
        .serial_out_o(ser[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(2)) dut3 (
        .clk(clk), .n_rst(n_rst), .tx_data_i(tx_data), .tx_valid_i(v[3]), .tx_ready_o(rdy[3]),
        .serial_out_o(ser[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]));

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s@%0d: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input int d, input logic [7:0] w, input bit hold, input string tag);
        tx_data = w;
        v[d]    = 1'b1;
        check({tag, " ready"}, -1, 32'(rdy[d]), 32'd1);
        tick;
        if (!hold) v[d] = 1'b0;
    endtask

    task automatic idle_check(input int d, input string tag);
        check({tag, " idle ser"}, -1, 32'(ser[d]), 32'd1);
        check({tag, " idle rdy"}, -1, 32'(rdy[d]), 32'd1);
        check({tag, " idle busy"}, -1, 32'(busy[d]), 32'd0);
        check({tag, " idle done"}, -1, 32'(done[d]), 32'd0);
    endtask

    // Starts in the first START cycle; frame[b] is the expected line level of bit b.
    task automatic check_frame(input int d, input logic [15:0] frame, input int nbits,
                               input int cpb, input int pulse_at, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                int k;
                k = b * cpb + c;
                if (pulse_at >= 0 && k == pulse_at) begin
                    tx_data = 8'h3C;
                    v[d]    = 1'b1;
                end
                if (pulse_at >= 0 && k == pulse_at + 1) v[d] = 1'b0;
                check({tag, " ser"}, k, 32'(ser[d]), 32'(frame[b]));
                check({tag, " done"}, k, 32'(done[d]), 32'(b == nbits - 1 && c == cpb - 1));
                check({tag, " rdy"}, k, 32'(rdy[d]), 32'd0);
                check({tag, " busy"}, k, 32'(busy[d]), 32'd1);
                tick;
            end
        end
    endtask

    initial begin
        n_rst   = 1'b0;
        v       = '0;
        tx_data = '0;
        #2;
        for (int i = 0; i < 4; i++) idle_check(i, "reset");
        #20 n_rst = 1'b1;
        tick;

        // 0xA5, 8N1
        handshake(0, 8'hA5, 1'b0, "t1");
        f = 16'b000000_1_10100101_0;
        check_frame(0, f, 10, 4, -1, "t1");
        idle_check(0, "t1");

        // 0x07 with even then odd parity
        handshake(1, 8'h07, 1'b0, "t2e");
        f = 16'b00000_1_1_00000111_0;
        check_frame(1, f, 11, 4, -1, "t2e");
        idle_check(1, "t2e");
        handshake(2, 8'h07, 1'b0, "t2o");
        f = 16'b00000_1_0_00000111_0;
        check_frame(2, f, 11, 4, -1, "t2o");
        idle_check(2, "t2o");

        // Back-to-back with valid held high
        handshake(0, 8'h00, 1'b1, "t3a");
        tx_data = 8'hFF;
        f = 16'b000000_1_00000000_0;
        check_frame(0, f, 10, 4, -1, "t3a");
        check("t3 gap ser", -1, 32'(ser[0]), 32'd1);
        check("t3 gap rdy", -1, 32'(rdy[0]), 32'd1);
        tick;
        v[0] = 1'b0;
        f = 16'b000000_1_11111111_0;
        check_frame(0, f, 10, 4, -1, "t3b");
        idle_check(0, "t3b");

        // Mid-frame valid pulse must be ignored and not queued
        handshake(0, 8'h55, 1'b0, "t4");
        f = 16'b000000_1_01010101_0;
        check_frame(0, f, 10, 4, 12, "t4");
        idle_check(0, "t4");
        tick;
        tick;
        idle_check(0, "t4 after");

        // Async reset during data bit 3
        handshake(0, 8'hF0, 1'b0, "t5");
        for (int i = 0; i < 17; i++) tick;
        check("t5 pre-reset ser", 17, 32'(ser[0]), 32'd0);
        n_rst = 1'b0;
        #2;
        idle_check(0, "t5 reset");
        #2 n_rst = 1'b1;
        tick;
        handshake(0, 8'h81, 1'b0, "t5b");
        f = 16'b000000_1_10000001_0;
        check_frame(0, f, 10, 4, -1, "t5b");
        idle_check(0, "t5b");

        // Two stop bits at 2 clocks per bit
        handshake(3, 8'h5A, 1'b0, "t6");
        f = 16'b00000_11_01011010_0;
        check_frame(3, f, 11, 2, -1, "t6");
        idle_check(3, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
